// File: rtl/mem_access_unit_if.sv
// Load/store unit bus: controller request/response plus DataMemory initiator signals.
// master = the load/store unit, slave = controller and DataMemory side.
interface mem_access_unit_if #(
  parameter int WL = 32,
  parameter int AW = 32
);
  logic          start;
  logic          isStore;
  logic [2:0]    funct3;
  logic [AW-1:0] address;
  logic [WL-1:0] storeData;
  logic          busy;
  logic          done;
  logic          misaligned;
  logic [WL-1:0] loadData;
  logic [AW-1:0] memAddress;
  logic [WL-1:0] memDataOUT;
  logic          memWriteEN;
  logic [WL-1:0] memDataIN;

  modport master (
    input  start, isStore, funct3, address, storeData, memDataIN,
    output busy, done, misaligned, loadData, memAddress, memDataOUT, memWriteEN
  );
  modport slave (
    output start, isStore, funct3, address, storeData, memDataIN,
    input  busy, done, misaligned, loadData, memAddress, memDataOUT, memWriteEN
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle RISC-V load/store unit: lane select, extension, read-modify-write for
// sub-word stores and alignment rejection, with a start/done handshake.
module mem_access_unit #(
  parameter int WL = 32,
  parameter int AW = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.master  bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state, state_nx;
  logic          is_store, mis;
  logic [2:0]    f3;
  logic [AW-1:0] addr;
  logic [WL-1:0] sdata, word, load_data;
  logic          reject;

  // Request check is done on the raw inputs so a rejected request skips memory entirely.
  always_comb begin
    reject = 1'b1;
    case (bus.funct3)
      3'b000:  reject = 1'b0;
      3'b001:  reject = bus.address[0];
      3'b010:  reject = |bus.address[1:0];
      3'b100:  reject = bus.isStore;
      3'b101:  reject = bus.isStore | bus.address[0];
      default: reject = 1'b1;
    endcase
  end

  function automatic logic [WL-1:0] extend(input logic [WL-1:0] w, input logic [1:0] a,
                                           input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (f)
      3'b000:  extend = {{(WL-8){b[7]}}, b};
      3'b001:  extend = {{(WL-16){h[15]}}, h};
      3'b100:  extend = {{(WL-8){1'b0}}, b};
      3'b101:  extend = {{(WL-16){1'b0}}, h};
      default: extend = w;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) begin
                 if (reject)                                  state_nx = DONE;
                 else if (bus.isStore && bus.funct3 == 3'b010) state_nx = WRITE;
                 else                                         state_nx = READ;
               end
      READ:    state_nx = is_store ? WRITE : DONE;
      WRITE:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      is_store  <= 1'b0;
      mis       <= 1'b0;
      f3        <= '0;
      addr      <= '0;
      sdata     <= '0;
      word      <= '0;
      load_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) begin
        is_store <= bus.isStore;
        f3       <= bus.funct3;
        addr     <= bus.address;
        sdata    <= bus.storeData;
        mis      <= reject;
      end
      if (state == READ) begin
        if (is_store) word      <= bus.memDataIN;
        else          load_data <= extend(bus.memDataIN, addr[1:0], f3);
      end
    end
  end

  // Sub-word stores merge into the word captured during READ.
  always_comb begin
    bus.memDataOUT = word;
    if (f3 == 3'b000)      bus.memDataOUT[{addr[1:0], 3'b000} +: 8]  = sdata[7:0];
    else if (f3 == 3'b001) bus.memDataOUT[{addr[1], 4'b0000} +: 16]  = sdata[15:0];
    else                   bus.memDataOUT = sdata;
  end

  assign bus.memAddress = {addr[AW-1:2], 2'b00};
  assign bus.memWriteEN = (state == WRITE);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.misaligned = (state == DONE) && mis;
  assign bus.loadData   = load_data;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store unit for the RISC_V core. It sits between the core controller and the word-wide DataMemory, and is the initiator side of the DataMemory interface (address, write data, write enable, combinational read data). It runs the RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW semantics: byte-lane selection, sign/zero extension, read-modify-write for sub-word stores, and alignment checking. It reports completion to the controller with a start/done handshake.

## Interface
- WL, 32, data word width (byte lanes = WL/8, fixed 4)
- AW, 32, byte-address width

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request strobe, sampled only in IDLE
- isStore  in  1  1 = store, 0 = load (sampled with start)
- funct3  in  3  RISC-V width/sign code (sampled with start)
- address  in  AW  byte address (sampled with start)
- storeData  in  WL  rs2 value (sampled with start)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- misaligned  out  1  high with done when the request was rejected
- loadData  out  WL  extended load result, held until the next completed load
- memAddress  out  AW  word address to DataMemory, {addr[AW-1:2],2'b00}
- memDataOUT  out  WL  write word to DataMemory dataIN
- memWriteEN  out  1  DataMemory write enable
- memDataIN  in  WL  DataMemory dataOUT, combinational read of memAddress

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE + start: register isStore, funct3, address, and storeData. Drive memAddress from the registered address.
- Reject conditions:
  - funct3 not in {000,001,010,100,101} for a load.
  - funct3 not in {000,001,010} for a store.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
  - Rejected requests go IDLE→DONE with misaligned=1. memWriteEN is never asserted and loadData is unchanged.
- Load: IDLE→READ→DONE. Capture memDataIN at the end of READ, then select and extend.
- SW: IDLE→WRITE→DONE. memDataOUT = storeData.
- SB/SH: IDLE→READ→WRITE→DONE. The READ word is captured. The WRITE word is the captured word with the addressed lane(s) replaced by storeData[7:0] or storeData[15:0].
- Byte lanes are little-endian: byte k = word[8k+7:8k], k = addr[1:0]; halfword lane = addr[1].
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- DONE→IDLE unconditionally.
- start while busy is ignored; it is neither queued nor sampled.

## Timing
- Reset values: state IDLE; busy, done, misaligned, memWriteEN = 0; loadData, memAddress, memDataOUT = 0.
- memWriteEN is high for exactly the one cycle spent in WRITE. memAddress and memDataOUT are stable that whole cycle; DataMemory writes on the closing edge.
- Latency, counted in edges from the edge that samples start until done=1:
  - Load: 2.
  - SW: 2.
  - SB/SH: 3.
  - Rejected: 1.
- loadData is valid in the same cycle as done. It updates only on a successful load.
- busy goes high the cycle after start is sampled and is low in the cycle after DONE. A new start may be sampled on the edge that leaves DONE→IDLE, i.e. the first IDLE cycle.
- Reset mid-operation: on the next edge, return to IDLE with all outputs at reset values. No done pulse is issued. If rst is high during WRITE, the write edge still coincides with rst, so DataMemory's own reset takes priority; the unit guarantees memWriteEN=0 from the following cycle on.

## Test plan
- Reset: hold rst for 3 cycles with start=1 -> busy=0, done=0, memWriteEN=0, and loadData=0 throughout.
- Loads (mem[0x10]=0x8123_45F6):
  - LW 0x10 -> loadData 0x8123_45F6, done 2 edges after start.
  - LB 0x13 -> 0xFFFF_FF81.
  - LBU 0x13 -> 0x0000_0081.
  - LH 0x12 -> 0xFFFF_8123.
  - LHU 0x10 -> 0x0000_45F6.
- SB 0x11, storeData 0x1234_56AA (same word) -> exactly one memWriteEN cycle with memDataOUT 0x8123_AAF6. Done 3 edges after start. A following LW 0x10 returns 0x8123_AAF6.
- SW 0x14, data 0xDEAD_BEEF -> one write cycle, memAddress 0x14, done 2 edges after start. SH 0x16, data 0x0000_CAFE then gives word 0xCAFE_BEEF.
- Misaligned LW 0x12 and SH 0x11 -> done and misaligned after 1 edge, memWriteEN never high, loadData unchanged. An invalid load funct3=011 behaves the same.
- Assert rst during READ of SB 0x11 -> no memWriteEN, no done, memory word unchanged, unit in IDLE and accepting start after rst is released.
